// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: hazard-unit controls, branch redirect, instruction memory port and IF/ID
// register outputs. The fetch stage uses the master modport and its environment uses slave.
interface if_fetch_stage_if;
   logic        pc_write;
   logic        if_id_write;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] pc_out;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;

   modport master (
      input  pc_write,
      input  if_id_write,
      input  branch_taken,
      input  branch_target,
      input  imem_rdata,
      output imem_addr,
      output pc_out,
      output if_id_instr,
      output if_id_pc4,
      output if_id_valid
   );

   modport slave (
      output pc_write,
      output if_id_write,
      output branch_taken,
      output branch_target,
      output imem_rdata,
      input  imem_addr,
      input  pc_out,
      input  if_id_instr,
      input  if_id_pc4,
      input  if_id_valid
   );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS R2000 instruction-fetch stage: PC register, next-PC selection, IF/ID pipeline register
// and j-type jump resolution at fetch (no delay slot; the jump slot becomes a bubble).
// Optional macro FETCH_PERF_CNT_EN adds saturating stall/flush/jump event counters.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000,
   parameter logic [5:0]  J_OPCODE = 6'b000010
) (
   input  logic                clk,
   input  logic                rst,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]         stall_cnt,
   output logic [31:0]         flush_cnt,
   output logic [31:0]         jump_cnt,
`endif
   if_fetch_stage_if.master    bus
);

   logic [31:0] r_pc,    w_pc_d;
   logic [31:0] r_instr, w_instr_d;
   logic [31:0] r_pc4,   w_pc4_d;
   logic        r_valid, w_valid_d;

   logic [31:0] w_pc4;
   logic        w_is_jump;
   logic [31:0] w_jtarget;
   logic        w_unused_bt_lsb;

   assign w_pc4     = r_pc + 32'd4;
   assign w_is_jump = (bus.imem_rdata[31:26] == J_OPCODE);
   assign w_jtarget = {w_pc4[31:28], bus.imem_rdata[25:0], 2'b00};

   // Branch targets are word-aligned by dropping the two low bits.
   assign w_unused_bt_lsb = ^bus.branch_target[1:0];

   assign bus.imem_addr   = r_pc;
   assign bus.pc_out      = r_pc;
   assign bus.if_id_instr = r_instr;
   assign bus.if_id_pc4   = r_pc4;
   assign bus.if_id_valid = r_valid;

   // Next-PC and IF/ID selection: branch redirect > stall > jump > sequential.
   always_comb begin
      w_pc_d    = r_pc;
      w_instr_d = r_instr;
      w_pc4_d   = r_pc4;
      w_valid_d = r_valid;
      if (bus.branch_taken) begin
         // Older instruction in ID wins over a stall or a jump sitting in IF.
         w_pc_d    = {bus.branch_target[31:2], 2'b00};
         w_instr_d = NOP_WORD;
         w_pc4_d   = 32'd0;
         w_valid_d = 1'b0;
      end else if (!bus.pc_write) begin
         if (bus.if_id_write) begin
            w_instr_d = bus.imem_rdata;
            w_pc4_d   = w_pc4;
            w_valid_d = 1'b1;
         end
      end else if (w_is_jump) begin
         // The jump itself is squashed; PC+4 is never fetched.
         w_pc_d = w_jtarget;
         if (bus.if_id_write) begin
            w_instr_d = NOP_WORD;
            w_pc4_d   = w_pc4;
            w_valid_d = 1'b0;
         end
      end else begin
         w_pc_d = w_pc4;
         if (bus.if_id_write) begin
            w_instr_d = bus.imem_rdata;
            w_pc4_d   = w_pc4;
            w_valid_d = 1'b1;
         end
      end
   end

   // PC and IF/ID registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc    <= RESET_PC;
         r_instr <= NOP_WORD;
         r_pc4   <= 32'd0;
         r_valid <= 1'b0;
      end else begin
         r_pc    <= w_pc_d;
         r_instr <= w_instr_d;
         r_pc4   <= w_pc4_d;
         r_valid <= w_valid_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;
   logic [31:0] r_jump_cnt;
   logic        w_ev_stall;
   logic        w_ev_jump;

   assign w_ev_stall = !bus.pc_write && !bus.branch_taken;
   assign w_ev_jump  = !bus.branch_taken && bus.pc_write && w_is_jump;

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= 32'd0;
         r_flush_cnt <= 32'd0;
         r_jump_cnt  <= 32'd0;
      end else begin
         if (w_ev_stall && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
         if (bus.branch_taken && (r_flush_cnt != 32'hFFFF_FFFF)) begin
            r_flush_cnt <= r_flush_cnt + 32'd1;
         end
         if (w_ev_jump && (r_jump_cnt != 32'hFFFF_FFFF)) r_jump_cnt <= r_jump_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
   assign jump_cnt  = r_jump_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the fetch rules. Honours FETCH_PERF_CNT_EN when defined.
module tb_if_fetch_stage;

   logic clk;
   logic rst;
   if_fetch_stage_if bus ();

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt, jump_cnt;
`endif

   if_fetch_stage dut (
      .clk       (clk),
      .rst       (rst),
`ifdef FETCH_PERF_CNT_EN
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt),
      .jump_cnt  (jump_cnt),
`endif
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Instruction memory: sparse, unwritten words read as addi with address-derived bits.
   logic [31:0] mem [logic [31:0]];
   bit          seen_1c;

   // Reference model state.
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid;
   logic [31:0] m_stall, m_flush, m_jump;

   wire [128:0] obs = {bus.imem_addr, bus.pc_out, bus.if_id_instr, bus.if_id_pc4,
                       bus.if_id_valid};
   wire [128:0] mdl = {m_pc, m_pc, m_instr, m_pc4, m_valid};

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {6'b001000, a[25:0]};
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // One clock: apply inputs, advance the model, sample 1 time unit after the edge.
   task automatic step(input bit r, input bit pw, input bit iw, input bit bt,
                       input logic [31:0] btgt);
      logic [31:0] word, npc4;
      rst               = r;
      bus.pc_write      = pw;
      bus.if_id_write   = iw;
      bus.branch_taken  = bt;
      bus.branch_target = btgt;
      bus.imem_rdata    = mem_rd(bus.imem_addr);
      if (bus.imem_addr == 32'h1C) seen_1c = 1'b1;
      if (!r && !bt && !pw && iw) $display("WARNING: pc_write=0 with if_id_write=1");
      if (r) begin
         m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
         m_stall = 0; m_flush = 0; m_jump = 0;
      end else begin
         word = mem_rd(m_pc);
         npc4 = m_pc + 32'd4;
         if (bt) begin
            m_flush = sat_inc(m_flush);
            m_pc    = btgt & 32'hFFFF_FFFC;
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
         end else if (!pw) begin
            m_stall = sat_inc(m_stall);
            if (iw) begin m_instr = word; m_pc4 = npc4; m_valid = 1'b1; end
         end else if (word[31:26] == 6'd2) begin
            m_jump = sat_inc(m_jump);
            m_pc   = (npc4 & 32'hF000_0000) | ({6'b0, word[25:0]} << 2);
            if (iw) begin m_instr = 32'h0; m_pc4 = npc4; m_valid = 1'b0; end
         end else begin
            m_pc = npc4;
            if (iw) begin m_instr = word; m_pc4 = npc4; m_valid = 1'b1; end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(1, 1, 1, 0, 32'h0);
      n_checks++;
      if (obs !== {32'h0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
         n_errors++;
         $display("FAIL reset_state: got %h required %h", obs, {32'h0, 32'h0, 32'h0, 32'h0, 1'b0});
      end
      // Reset must override a concurrent branch redirect.
      step(1, 0, 0, 1, 32'h80);
      n_checks++;
      if (obs !== {32'h0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
         n_errors++;
         $display("FAIL reset_overrides_branch: got %h required 0", obs);
      end
   endtask

   task automatic test_sequential();
      logic [31:0] w [7] = '{32'h20420002, 32'h20630003, 32'h20840004, 32'h20a50005,
                             32'h20c60006, 32'h20e70007, 32'h08000040};
      for (int i = 0; i < 7; i++) mem[32'(4 * i)] = w[i];
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (bus.imem_addr !== 32'(4 * i)) begin
            n_errors++;
            $display("FAIL seq_addr[%0d]: got %h required %h", i, bus.imem_addr, 4 * i);
         end
         step(0, 1, 1, 0, 32'h0);
         n_checks++;
         if ({bus.if_id_instr, bus.if_id_pc4, bus.if_id_valid} !== {w[i], 32'(4 * i + 4), 1'b1})
         begin
            n_errors++;
            $display("FAIL seq_ifid[%0d]: got %h/%h/%b required %h/%h/1", i, bus.if_id_instr,
                     bus.if_id_pc4, bus.if_id_valid, w[i], 4 * i + 4);
         end
      end
   endtask

   task automatic test_jump();
      seen_1c = 1'b0;
      step(0, 1, 1, 0, 32'h0);
      n_checks++;
      if ({bus.pc_out, bus.if_id_instr, bus.if_id_pc4, bus.if_id_valid} !==
          {32'h100, 32'h0, 32'h1C, 1'b0}) begin
         n_errors++;
         $display("FAIL jump_resolve: got pc=%h instr=%h pc4=%h v=%b required pc=100 instr=0 pc4=1c v=0",
                  bus.pc_out, bus.if_id_instr, bus.if_id_pc4, bus.if_id_valid);
      end
      step(0, 1, 1, 0, 32'h0);
      step(0, 1, 1, 0, 32'h0);
      n_checks++;
      if (seen_1c !== 1'b0) begin
         n_errors++;
         $display("FAIL jump_no_slot: address 1c presented=%b required 0", seen_1c);
      end
      n_checks++;
      if (obs !== mdl) begin
         n_errors++;
         $display("FAIL jump_follow: got %h required %h", obs, mdl);
      end
   endtask

   task automatic test_stall();
      step(1, 1, 1, 0, 32'h0);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 32'h0);
         n_checks++;
         if ({bus.pc_out, bus.if_id_instr, bus.if_id_pc4, bus.if_id_valid} !==
             {32'h0C, 32'h20840004, 32'h0C, 1'b1}) begin
            n_errors++;
            $display("FAIL stall_hold[%0d]: got pc=%h instr=%h pc4=%h v=%b", i, bus.pc_out,
                     bus.if_id_instr, bus.if_id_pc4, bus.if_id_valid);
         end
      end
      step(0, 1, 1, 0, 32'h0);
      n_checks++;
      if ({bus.pc_out, bus.if_id_instr} !== {32'h10, 32'h20a50005}) begin
         n_errors++;
         $display("FAIL stall_release: got pc=%h instr=%h required pc=10 instr=20a50005",
                  bus.pc_out, bus.if_id_instr);
      end
   endtask

   task automatic test_branch_stall();
      step(0, 0, 0, 1, 32'h2A);
      n_checks++;
      if ({bus.pc_out, bus.if_id_instr, bus.if_id_pc4, bus.if_id_valid} !==
          {32'h28, 32'h0, 32'h0, 1'b0}) begin
         n_errors++;
         $display("FAIL branch_over_stall: got pc=%h instr=%h pc4=%h v=%b required 28/0/0/0",
                  bus.pc_out, bus.if_id_instr, bus.if_id_pc4, bus.if_id_valid);
      end
   endtask

   task automatic test_jump_vs_branch();
      mem[32'h28] = 32'h08000080;
      step(0, 1, 1, 1, 32'h40);
      n_checks++;
      if ({bus.pc_out, bus.if_id_valid} !== {32'h40, 1'b0}) begin
         n_errors++;
         $display("FAIL jump_vs_branch: got pc=%h v=%b required pc=40 v=0", bus.pc_out,
                  bus.if_id_valid);
      end
`ifdef FETCH_PERF_CNT_EN
      n_checks++;
      if ({flush_cnt, jump_cnt, stall_cnt} !== {m_flush, m_jump, m_stall}) begin
         n_errors++;
         $display("FAIL jump_vs_branch_cnt: got %0d/%0d/%0d required %0d/%0d/%0d", flush_cnt,
                  jump_cnt, stall_cnt, m_flush, m_jump, m_stall);
      end
`endif
   endtask

   task automatic test_wrap();
      step(0, 1, 1, 1, 32'hFFFF_FFFF);
      step(0, 1, 1, 0, 32'h0);
      n_checks++;
      if ({bus.pc_out, bus.if_id_instr, bus.if_id_pc4, bus.if_id_valid} !==
          {32'h0, 32'h23FFFFFC, 32'h0, 1'b1}) begin
         n_errors++;
         $display("FAIL pc_wrap: got pc=%h instr=%h pc4=%h v=%b required 0/23fffffc/0/1",
                  bus.pc_out, bus.if_id_instr, bus.if_id_pc4, bus.if_id_valid);
      end
   endtask

   task automatic test_reset_mid_stall();
      step(0, 1, 1, 0, 32'h0);
      step(0, 0, 0, 0, 32'h0);
      step(0, 0, 0, 0, 32'h0);
      step(1, 0, 0, 1, 32'h80);
      n_checks++;
      if (obs !== {32'h0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
         n_errors++;
         $display("FAIL reset_mid_stall: got %h required 0", obs);
      end
`ifdef FETCH_PERF_CNT_EN
      n_checks++;
      if ({stall_cnt, flush_cnt, jump_cnt} !== 96'h0) begin
         n_errors++;
         $display("FAIL reset_cnt: got %0d/%0d/%0d required 0/0/0", stall_cnt, flush_cnt,
                  jump_cnt);
      end
`endif
   endtask

   task automatic test_random();
      bit r, pw, iw, bt;
      int sel;
      mem.delete();
      for (int i = 0; i < 64; i++) begin
         if ($urandom_range(0, 4) == 0) mem[32'(4 * i)] = 32'h08000000 | $urandom_range(0, 63);
         else mem[32'(4 * i)] = {6'b001000, 26'($urandom)};
      end
      step(1, 1, 1, 0, 32'h0);
      for (int c = 0; c < 400; c++) begin
         r   = ($urandom_range(0, 63) == 0);
         bt  = ($urandom_range(0, 7) == 0);
         sel = $urandom_range(0, 5);
         pw  = (sel != 0);
         iw  = (sel > 1);
         step(r, pw, iw, bt, 32'($urandom_range(0, 255)));
         n_checks++;
         if (obs !== mdl) begin
            n_errors++;
            $display("FAIL random[%0d]: got %h required %h", c, obs, mdl);
         end
`ifdef FETCH_PERF_CNT_EN
         n_checks++;
         if ({stall_cnt, flush_cnt, jump_cnt} !== {m_stall, m_flush, m_jump}) begin
            n_errors++;
            $display("FAIL random_cnt[%0d]: got %0d/%0d/%0d required %0d/%0d/%0d", c,
                     stall_cnt, flush_cnt, jump_cnt, m_stall, m_flush, m_jump);
         end
`endif
      end
   endtask

   initial begin
      rst               = 1'b1;
      bus.pc_write      = 1'b0;
      bus.if_id_write   = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = 32'h0;
      bus.imem_rdata    = 32'h0;
      seen_1c           = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_sequential();
      test_jump();
      test_stall();
      test_branch_stall();
      test_jump_vs_branch();
      test_wrap();
      test_reset_mid_stall();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
